// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RV32I pipeline: a shadow
// scoreboard of E/M/W drives stalls, bubbles, operand forwarding and halt.
module pipe_hazard_ctrl #(
  parameter bit W_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_valid,
  input  logic [6:0]  d_opcode,
  input  logic [4:0]  d_rd,
  input  logic [4:0]  d_rs1,
  input  logic [4:0]  d_rs2,
  input  logic        e_redirect,
  input  logic        dmem_busy,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        stall_w,
  output logic        bubble_d,
  output logic        bubble_e,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        halt,
  output logic [56:0] dbg_shadow
);

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       ld;
    logic       ecall;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ent_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  ent_t d_ent, e_q, m_q, w_q;
  logic load_use, w_haz;

  // Decode D into a shadow entry; unused rs fields stay zero so they never match.
  always_comb begin
    d_ent       = '0;
    d_ent.valid = d_valid;
    d_ent.rd    = d_rd;
    unique case (d_opcode)
      OP_R:                       begin d_ent.wr = 1'b1; d_ent.rs1 = d_rs1; d_ent.rs2 = d_rs2; end
      OP_I, OP_JALR:              begin d_ent.wr = 1'b1; d_ent.rs1 = d_rs1; end
      OP_LOAD:                    begin d_ent.wr = 1'b1; d_ent.ld = 1'b1; d_ent.rs1 = d_rs1; end
      OP_JAL, OP_LUI, OP_AUIPC:   d_ent.wr = 1'b1;
      OP_STORE, OP_BR:            begin d_ent.rs1 = d_rs1; d_ent.rs2 = d_rs2; end
      OP_ECALL:                   d_ent.ecall = 1'b1;
      default:                    d_ent.wr = 1'b0;
    endcase
    if (d_rd == 5'd0) d_ent.wr = 1'b0;
  end

  function automatic logic hits(input ent_t p, input ent_t d);
    return p.valid && p.wr && d.valid &&
           (((d.rs1 != 5'd0) && (p.rd == d.rs1)) ||
            ((d.rs2 != 5'd0) && (p.rd == d.rs2)));
  endfunction

  function automatic logic [1:0] fsel(input logic [4:0] rs, input ent_t m, input ent_t w);
    if (rs != 5'd0 && m.valid && m.wr && m.rd == rs)      return 2'b01;
    else if (rs != 5'd0 && w.valid && w.wr && w.rd == rs) return 2'b10;
    else                                                  return 2'b00;
  endfunction

  assign load_use = hits(e_q, d_ent) && e_q.ld;
  assign w_haz    = !W_BYPASS && hits(w_q, d_ent);

  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    stall_w  = 1'b0;
    bubble_d = 1'b0;
    bubble_e = 1'b0;
    if (dmem_busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      stall_w = 1'b1;
    end else if (e_redirect) begin
      bubble_d = 1'b1;
      bubble_e = 1'b1;
    end else if (load_use || w_haz) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      bubble_e = 1'b1;
    end
  end

  assign fwd_a      = fsel(e_q.rs1, m_q, w_q);
  assign fwd_b      = fsel(e_q.rs2, m_q, w_q);
  assign dbg_shadow = {e_q, m_q, w_q};

  // A freeze holds the whole shadow, so the E instruction and halt wait too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q  <= '0;
      m_q  <= '0;
      w_q  <= '0;
      halt <= 1'b0;
    end else if (!dmem_busy) begin
      w_q <= m_q;
      m_q <= e_q;
      e_q <= (d_valid && !bubble_e) ? d_ent : '0;
      if (w_q.valid && w_q.ecall) halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: packs all control outputs into one
// vector and compares each cycle against hand-computed expectations.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ECALL = 7'b1110011;
  localparam logic [11:0] IDLE    = 12'h000;

  logic        clk, rst_n;
  logic        d_valid, e_redirect, dmem_busy;
  logic [6:0]  d_opcode;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic        stall_f, stall_d, stall_e, stall_m, stall_w, bubble_d, bubble_e, halt;
  logic [1:0]  fwd_a, fwd_b;
  logic [56:0] dbg_shadow;
  logic        nb_stall_f, nb_stall_d, nb_stall_e, nb_stall_m, nb_stall_w;
  logic        nb_bubble_d, nb_bubble_e, nb_halt;
  logic [1:0]  nb_fwd_a, nb_fwd_b;
  logic [56:0] nb_dbg_shadow;
  logic [11:0] ctrl_vec, nb_vec;

  logic [11:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_opcode(d_opcode),
    .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2), .e_redirect(e_redirect),
    .dmem_busy(dmem_busy), .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w),
    .bubble_d(bubble_d), .bubble_e(bubble_e), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .halt(halt), .dbg_shadow(dbg_shadow)
  );

  pipe_hazard_ctrl #(.W_BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_opcode(d_opcode),
    .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2), .e_redirect(e_redirect),
    .dmem_busy(dmem_busy), .stall_f(nb_stall_f), .stall_d(nb_stall_d),
    .stall_e(nb_stall_e), .stall_m(nb_stall_m), .stall_w(nb_stall_w),
    .bubble_d(nb_bubble_d), .bubble_e(nb_bubble_e), .fwd_a(nb_fwd_a),
    .fwd_b(nb_fwd_b), .halt(nb_halt), .dbg_shadow(nb_dbg_shadow)
  );

  assign ctrl_vec = {stall_f, stall_d, stall_e, stall_m, stall_w,
                     bubble_d, bubble_e, fwd_a, fwd_b, halt};
  assign nb_vec   = {nb_stall_f, nb_stall_d, nb_stall_e, nb_stall_m, nb_stall_w,
                     nb_bubble_d, nb_bubble_e, nb_fwd_a, nb_fwd_b, nb_halt};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] mk(input logic [4:0] st, input logic bd, input logic be,
                                     input logic [1:0] fa, input logic [1:0] fb, input logic h);
    return {st, bd, be, fa, fb, h};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got stall=%b bd=%b be=%b fa=%b fb=%b halt=%b, expected stall=%b bd=%b be=%b fa=%b fb=%b halt=%b",
               tag, got[11:7], got[6], got[5], got[4:3], got[2:1], got[0],
               exp[11:7], exp[6], exp[5], exp[4:3], exp[2:1], exp[0]);
    end
  endtask

  // Driver tasks
  task automatic drive_d(input logic v, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
    d_valid  = v;
    d_opcode = op;
    d_rd     = rd;
    d_rs1    = rs1;
    d_rs2    = rs2;
  endtask

  task automatic nop();
    drive_d(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
  endtask

  // Settle, compare the main DUT against the expected queue, then advance one edge.
  task automatic cyc(input string tag, input logic [11:0] exp);
    #1;
    exp_q.push_back(exp);
    check(tag, ctrl_vec, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    nop();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    e_redirect = 1'b0;
    dmem_busy = 1'b0;
    nop();
    #12;
    check("reset", ctrl_vec, IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // add x5,x1,x2 ; sub x6,x5,x3
    drive_d(1'b1, OP_R, 5'd5, 5'd1, 5'd2);  cyc("b2b_add_d", IDLE);
    drive_d(1'b1, OP_R, 5'd6, 5'd5, 5'd3);  cyc("b2b_sub_d", IDLE);
    nop();                                  cyc("b2b_fwd_m", mk(5'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0));
    flush();

    // lw x7,0(x1) ; add x8,x7,x7
    drive_d(1'b1, OP_LOAD, 5'd7, 5'd1, 5'd0); cyc("lu_lw_d", IDLE);
    drive_d(1'b1, OP_R, 5'd8, 5'd7, 5'd7);    cyc("lu_stall", mk(5'b11000, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0));
    cyc("lu_released", IDLE);
    nop();                                    cyc("lu_fwd_w", mk(5'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0));
    flush();

    // lw x0 ; add x1,x0,x0
    drive_d(1'b1, OP_LOAD, 5'd0, 5'd1, 5'd0); cyc("x0_lw_d", IDLE);
    drive_d(1'b1, OP_R, 5'd1, 5'd0, 5'd0);    cyc("x0_no_stall", IDLE);
    nop();                                    cyc("x0_no_fwd", IDLE);
    flush();

    // sw x5,0(x6) with rd field = 5 ; add x9,x5,x5
    drive_d(1'b1, OP_STORE, 5'd5, 5'd6, 5'd5); cyc("sw_d", IDLE);
    drive_d(1'b1, OP_R, 5'd9, 5'd5, 5'd5);     cyc("sw_dep_d", IDLE);
    nop();                                     cyc("sw_no_fwd_m", IDLE);
    cyc("sw_no_fwd_w", IDLE);
    flush();

    // Redirect in the same cycle as a load-use
    drive_d(1'b1, OP_LOAD, 5'd7, 5'd1, 5'd0); cyc("rd_lw_d", IDLE);
    drive_d(1'b1, OP_R, 5'd8, 5'd7, 5'd7);
    e_redirect = 1'b1;                        cyc("rd_redirect", mk(5'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0));
    e_redirect = 1'b0;
    nop();                                    cyc("rd_killed_e", IDLE);
    cyc("rd_bubble_m", IDLE);
    flush();

    // Freeze for 3 cycles with dependent sub in E (redirect held to show it is ignored)
    drive_d(1'b1, OP_R, 5'd5, 5'd1, 5'd2);  cyc("fz_add_d", IDLE);
    drive_d(1'b1, OP_R, 5'd6, 5'd5, 5'd5);  cyc("fz_sub_d", IDLE);
    nop();
    dmem_busy  = 1'b1;
    e_redirect = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc($sformatf("fz_hold%0d", i), mk(5'b11111, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0));
    dmem_busy  = 1'b0;
    e_redirect = 1'b0;
    cyc("fz_release", mk(5'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0));
    cyc("fz_advance", IDLE);
    flush();

    // ECALL reaches W; a freeze delays halt by one edge
    drive_d(1'b1, OP_ECALL, 5'd0, 5'd0, 5'd0); cyc("ec_d", IDLE);
    nop();                                     cyc("ec_e", IDLE);
    cyc("ec_m", IDLE);
    dmem_busy = 1'b1;                          cyc("ec_w_frozen", mk(5'b11111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
    dmem_busy = 1'b0;                          cyc("ec_w", IDLE);
    cyc("halt_set", mk(5'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
    cyc("halt_sticky", mk(5'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check("halt_async_clear", ctrl_vec, IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_d(1'b1, OP_R, 5'd4, 5'd4, 5'd4);     cyc("post_reset", IDLE);
    flush();

    // W-to-D hazard only matters without write-before-read bypass
    drive_d(1'b1, OP_R, 5'd5, 5'd1, 5'd2);  cyc("wh_add_d", IDLE);
    nop();                                  cyc("wh_gap1", IDLE);
    cyc("wh_gap2", IDLE);
    drive_d(1'b1, OP_R, 5'd6, 5'd5, 5'd0);
    #1;
    check("wh_nb_stall", nb_vec, mk(5'b11000, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0));
    cyc("wh_bypass_none", IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation still running, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
